// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: load-use bubble, redirect flush and memory freeze for IF/ID and ID/EX.
// Perf counters stall_cycles / flush_events exist only when STALL_COUNTERS_EN is defined.
module id_ex_hazard_ctrl #(
    parameter int CORE         = 0,
    parameter int ADDRESS_BITS = 20,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4:0]              id_rs1,
    input  logic [4:0]              id_rs2,
    input  logic                    id_uses_rs1,
    input  logic                    id_uses_rs2,
    input  logic [6:0]              ex_opcode,
    input  logic [4:0]              ex_rd,
    input  logic                    ex_redirect,
    input  logic [ADDRESS_BITS-1:0] ex_target,
    input  logic                    mem_busy,
    output logic                    pc_stall,
    output logic                    if_id_stall,
    output logic                    if_id_flush,
    output logic                    id_ex_stall,
    output logic                    id_ex_flush,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_PC,
    output logic [1:0]              hazard_state,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || CORE < 0) begin : g_param_check
        $error("id_ex_hazard_ctrl: illegal parameter value");
    end

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    state_t     eval_state;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Leaving MEM_WAIT resumes the saved state within the same cycle.
    assign eval_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d        = state_q;
        saved_d        = saved_q;
        cnt_d          = cnt_q;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_PC    = '0;
        if (reset) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            state_d     = MEM_WAIT;
            if (state_q != MEM_WAIT) saved_d = state_q;
        end else begin
            unique case (eval_state)
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    state_d     = (cnt_q == 3'd1) ? RUN : FLUSH;
                end
                default: begin
                    state_d = RUN;
                    if (ex_redirect) begin
                        redirect_valid = 1'b1;
                        redirect_PC    = ex_target;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FLUSH_LOAD;
                        end
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hazard_state = reset ? 2'd0 : state_q;

`ifdef STALL_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (redirect_valid && (flush_events_q != 32'hFFFF_FFFF))
            flush_events_d = flush_events_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = reset ? 32'd0 : stall_cycles_q;
    assign flush_events = reset ? 32'd0 : flush_events_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule
